seq_mul_arbiter: RTL and testbench

Shares one 4x4 sequential shift-add multiplier (seq_mul) between NUM_REQ requesters.
- Picks one requester per operation by round-robin and latches its operands.
- Pulses the multiplier start, counts the multiplier latency, then captures the 8-bit product.
- Returns the product with the requester ID over a valid/ready response channel.
- Sits between the requester-side logic and the seq_mul instance, and is the only driver of its start/a/b inputs.

---
 rtl/seq_mul_ctrl_pkg.sv | 20 ++
 rtl/rr_arbiter.sv | 43 ++++
 rtl/seq_mul_arbiter.sv | 154 +++++++++++++++
 tb/tb_seq_mul_arbiter.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/seq_mul_ctrl_pkg.sv
// rtl/seq_mul_ctrl_pkg.sv - shared types and widths for the seq_mul arbiter slice
// Contents: controller state enum, operand/product widths, requester-ID width helper.
package seq_mul_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_RUN,
    ST_RESP
  } state_e;

  localparam int OP_W   = 4;
  localparam int PROD_W = 8;

  // Width of a requester index; never narrower than one bit.
  function automatic int id_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick starting at a pointer
// Ports:
//   req_i     - request vector
//   ptr_i     - highest-priority index for this pick
//   grant_o   - one-hot grant (zero when no request)
//   winner_o  - encoded index of the granted request
//   any_req_o - at least one request is set
module rr_arbiter
  import seq_mul_ctrl_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = id_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [ID_W-1:0]    ptr_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [ID_W-1:0]    winner_o,
  output logic               any_req_o
);

  int              idx;
  logic [ID_W-1:0] idx_l;

  // Walk upward from ptr_i with wrap; the first set bit wins.
  always_comb begin
    grant_o   = '0;
    winner_o  = '0;
    any_req_o = 1'b0;
    idx       = 0;
    idx_l     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(ptr_i) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      idx_l = ID_W'(idx);
      if (!any_req_o && req_i[idx_l]) begin
        any_req_o = 1'b1;
        winner_o  = idx_l;
      end
    end
    if (any_req_o) grant_o[winner_o] = 1'b1;
  end

endmodule

// File: rtl/seq_mul_arbiter.sv
// rtl/seq_mul_arbiter.sv - round-robin sharing of one sequential 4x4 multiplier
// Optional: define SEQ_MUL_ZERO_BYPASS_EN to answer zero-operand requests without the multiplier.
// Ports:
//   clk, reset            - clock, synchronous active-high reset
//   req_valid/req_a/req_b - per-requester request and packed operands (4 bits per lane)
//   req_ready             - one-hot grant, only while idle
//   mul_start/mul_a/mul_b - drive to seq_mul; mul_op is its product
//   rsp_valid/rsp_ready   - response handshake; rsp_id/rsp_data carry requester and product
//   busy                  - controller not idle
module seq_mul_arbiter
  import seq_mul_ctrl_pkg::*;
#(
  parameter  int NUM_REQ    = 4,
  parameter  int MUL_CYCLES = 5,
  localparam int ID_W       = id_w(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [OP_W*NUM_REQ-1:0]  req_a,
  input  logic [OP_W*NUM_REQ-1:0]  req_b,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic                     mul_start,
  output logic [OP_W-1:0]          mul_a,
  output logic [OP_W-1:0]          mul_b,
  input  logic [PROD_W-1:0]        mul_op,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [ID_W-1:0]          rsp_id,
  output logic [PROD_W-1:0]        rsp_data,
  output logic                     busy
);

  localparam int              CNT_W    = $clog2(MUL_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MUL_CYCLES - 1);
  localparam logic [ID_W-1:0]  LAST_ID  = ID_W'(NUM_REQ - 1);

  state_e              state_q, state_d;
  logic [ID_W-1:0]     rr_q, rr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [OP_W-1:0]     a_q, a_d, b_q, b_d;
  logic [ID_W-1:0]     id_q, id_d;
  logic [ID_W-1:0]     rsp_id_q, rsp_id_d;
  logic [PROD_W-1:0]   rsp_data_q, rsp_data_d;

  logic [NUM_REQ-1:0]  grant;
  logic [ID_W-1:0]     winner;
  logic                any_req;
  logic [OP_W-1:0]     win_a, win_b;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr (
    .req_i     (req_valid),
    .ptr_i     (rr_q),
    .grant_o   (grant),
    .winner_o  (winner),
    .any_req_o (any_req)
  );

  // Operand mux for the winning lane.
  always_comb begin
    win_a = '0;
    win_b = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (winner == ID_W'(i)) begin
        win_a = req_a[i*OP_W +: OP_W];
        win_b = req_b[i*OP_W +: OP_W];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    rr_d       = rr_q;
    cnt_d      = cnt_q;
    a_d        = a_q;
    b_d        = b_q;
    id_d       = id_q;
    rsp_id_d   = rsp_id_q;
    rsp_data_d = rsp_data_q;
    case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          a_d     = win_a;
          b_d     = win_b;
          id_d    = winner;
          rr_d    = (winner == LAST_ID) ? '0 : winner + 1'b1;
          state_d = ST_START;
`ifdef SEQ_MUL_ZERO_BYPASS_EN
          // A zero operand makes the product known; skip the multiplier entirely.
          if (win_a == '0 || win_b == '0) begin
            rsp_data_d = '0;
            rsp_id_d   = winner;
            state_d    = ST_RESP;
          end
`endif
        end
      end
      ST_START: begin
        cnt_d   = CNT_LOAD;
        state_d = ST_RUN;
      end
      ST_RUN: begin
        // counter==0 marks the last RUN cycle, when mul_op has settled.
        if (cnt_q == '0) begin
          rsp_data_d = mul_op;
          rsp_id_d   = id_q;
          state_d    = ST_RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_RESP: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      rr_q       <= '0;
      cnt_q      <= '0;
      a_q        <= '0;
      b_q        <= '0;
      id_q       <= '0;
      rsp_id_q   <= '0;
      rsp_data_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_q       <= rr_d;
      cnt_q      <= cnt_d;
      a_q        <= a_d;
      b_q        <= b_d;
      id_q       <= id_d;
      rsp_id_q   <= rsp_id_d;
      rsp_data_q <= rsp_data_d;
    end
  end

  // Grant is masked during reset so nothing is handshaken that will be discarded.
  assign req_ready = (state_q == ST_IDLE && !reset) ? grant : '0;
  assign mul_start = (state_q == ST_START);
  assign mul_a     = a_q;
  assign mul_b     = b_q;
  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_seq_mul_arbiter.sv
// tb/tb_seq_mul_arbiter.sv - directed self-checking bench for seq_mul_arbiter
module tb_seq_mul_arbiter;

  localparam int NUM_REQ    = 4;
  localparam int MUL_CYCLES = 5;

  logic         clk = 1'b0;
  logic         reset;
  logic [3:0]   req_valid;
  logic [15:0]  req_a, req_b;
  logic [3:0]   req_ready;
  logic         mul_start;
  logic [3:0]   mul_a, mul_b;
  logic [7:0]   mul_op;
  logic         rsp_valid, rsp_ready;
  logic [1:0]   rsp_id;
  logic [7:0]   rsp_data;
  logic         busy;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  seq_mul_arbiter #(
    .NUM_REQ    (NUM_REQ),
    .MUL_CYCLES (MUL_CYCLES)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .mul_start (mul_start),
    .mul_a     (mul_a),
    .mul_b     (mul_b),
    .mul_op    (mul_op),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .busy      (busy)
  );

  // Multiplier stand-in: product only becomes visible MUL_CYCLES cycles after start.
  logic [7:0] prod_m = 8'h00;
  int         cnt_m  = 0;
  always @(posedge clk) begin
    if (mul_start) begin
      prod_m <= 8'(mul_a) * 8'(mul_b);
      cnt_m  <= MUL_CYCLES - 1;
    end else if (cnt_m != 0) begin
      cnt_m <= cnt_m - 1;
    end
  end
  assign mul_op = (cnt_m == 0) ? prod_m : 8'hEE;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic set_lane(input int i, input logic [3:0] a, input logic [3:0] b);
    req_a[4*i +: 4] = a;
    req_b[4*i +: 4] = b;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    req_valid = '0;
    rsp_ready = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  // Entered in the grant cycle with requests already driven; returns in the cycle after acceptance.
  task automatic do_op(input string tag, input int exp_id, input int exp_data,
                       input int exp_lat, input int exp_starts, input int hold);
    int lat, starts, stray;
    lat = 0; starts = 0; stray = 0;
    rsp_ready = (hold == 0);
    #1;
    check({tag, "_grant"}, 32'(req_ready), 32'd1 << exp_id);
    while (!rsp_valid && lat < 20) begin
      step();
      lat++;
      starts += int'(mul_start);
      if (req_ready != '0) stray++;
    end
    check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_starts"}, starts, exp_starts);
    check({tag, "_id"}, 32'(rsp_id), exp_id);
    check({tag, "_data"}, 32'(rsp_data), exp_data);
    for (int h = 0; h < hold; h++) begin
      step();
      check({tag, "_hold_valid"}, 32'(rsp_valid), 1);
      check({tag, "_hold_data"}, 32'(rsp_data), exp_data);
      check({tag, "_hold_id"}, 32'(rsp_id), exp_id);
      if (req_ready != '0) stray++;
    end
    rsp_ready = 1'b1;
    step();
    check({tag, "_rsp_done"}, 32'(rsp_valid), 0);
    check({tag, "_idle"}, 32'(busy), 0);
    check({tag, "_no_stray_grant"}, stray, 0);
  endtask

  initial begin
    reset     = 1'b1;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b1;

    // Reset state
    do_reset();
    check("rst_busy", 32'(busy), 0);
    check("rst_rsp_valid", 32'(rsp_valid), 0);
    check("rst_mul_start", 32'(mul_start), 0);
    check("rst_req_ready", 32'(req_ready), 0);
    check("rst_mul_ab", {24'd0, mul_a, mul_b}, 0);
    check("rst_rsp", {22'd0, rsp_id, rsp_data}, 0);

    // Single request from lane 2: 3*5
    set_lane(2, 4'd3, 4'd5);
    req_valid = 4'b0100;
    #1;
    check("t1_grant_c0", 32'(req_ready), 32'b0100);
    step();
    req_valid = '0;
    check("t1_start_c1", 32'(mul_start), 1);
    check("t1_mul_a", 32'(mul_a), 3);
    check("t1_mul_b", 32'(mul_b), 5);
    for (int c = 2; c < 7; c++) begin
      step();
      check("t1_run_no_valid", 32'(rsp_valid), 0);
      check("t1_run_no_start", 32'(mul_start), 0);
      check("t1_run_busy", 32'(busy), 1);
    end
    step();
    check("t1_valid_c7", 32'(rsp_valid), 1);
    check("t1_id", 32'(rsp_id), 2);
    check("t1_data", 32'(rsp_data), 15);
    step();
    check("t1_done", 32'(rsp_valid), 0);

    // All four requesting: round-robin 0,1,2,3 then 0 again
    do_reset();
    for (int i = 0; i < 4; i++) set_lane(i, 4'(i + 1), 4'd2);
    req_valid = 4'b1111;
    do_op("rr0", 0, 2, 7, 1, 0);
    do_op("rr1", 1, 4, 7, 1, 0);
    do_op("rr2", 2, 6, 7, 1, 0);
    do_op("rr3", 3, 8, 7, 1, 0);
    #1;
    check("rr_wrap_grant", 32'(req_ready), 32'b0001);

    // Backpressure: 15*15 held for 4 cycles, lane 1 waiting
    do_reset();
    set_lane(0, 4'd15, 4'd15);
    set_lane(1, 4'd1, 4'd1);
    req_valid = 4'b0011;
    do_op("bp", 0, 225, 7, 1, 4);
    #1;
    check("bp_next_grant", 32'(req_ready), 32'b0010);
    req_valid = 4'b0010;
    do_op("bp_next", 1, 1, 7, 1, 0);

    // Reset in the third RUN cycle abandons the op and clears rr_ptr
    do_reset();
    set_lane(2, 4'd2, 4'd3);
    req_valid = 4'b0100;
    #1;
    check("ra_grant", 32'(req_ready), 32'b0100);
    step();
    req_valid = '0;
    step();
    step();
    step();
    reset = 1'b1;
    set_lane(1, 4'd4, 4'd4);
    set_lane(3, 4'd5, 4'd5);
    req_valid = 4'b1010;
    step();
    reset = 1'b0;
    check("ra_busy", 32'(busy), 0);
    check("ra_rsp_valid", 32'(rsp_valid), 0);
    check("ra_mul_a", 32'(mul_a), 0);
    do_op("ra1", 1, 16, 7, 1, 0);
    do_op("ra3", 3, 25, 7, 1, 0);
    req_valid = '0;

    // Zero operands
`ifdef SEQ_MUL_ZERO_BYPASS_EN
    do_reset();
    set_lane(0, 4'd0, 4'd9);
    req_valid = 4'b0001;
    do_op("za", 0, 0, 1, 0, 0);
    do_reset();
    set_lane(0, 4'd7, 4'd0);
    req_valid = 4'b0001;
    do_op("zb", 0, 0, 1, 0, 0);
`else
    do_reset();
    set_lane(0, 4'd0, 4'd9);
    req_valid = 4'b0001;
    do_op("za", 0, 0, 7, 1, 0);
    do_reset();
    set_lane(0, 4'd7, 4'd0);
    req_valid = 4'b0001;
    do_op("zb", 0, 0, 7, 1, 0);
`endif
    req_valid = '0;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
